// File: rtl/booth_mult_param.sv
// Sequential radix-4 Booth multiply / multiply-accumulate, one Booth digit per clock,
// with a start-edge / busy / irq / ack handshake toward the bus-side controller.
module booth_mult_param #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               ack,
  input  logic               irq_enable,
  input  logic               signed_mode,
  input  logic               acc_mode,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               busy,
  output logic               irq,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned XW   = WIDTH + 2;
  localparam int unsigned AW   = 2 * WIDTH + 2;
  localparam int unsigned RW   = 2 * WIDTH;
  localparam int unsigned ITER = WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_WAIT} state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic [AW-1:0] a_q, a_d;
  logic [XW-1:0] b_q, b_d;
  logic          prev_q, prev_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] acc_q, acc_d;
  logic          acc_mode_q, acc_mode_d;
  logic          irq_en_q, irq_en_d;
  logic          busy_d, irq_d, done_d;
  logic [RW-1:0] result_d;

  logic          start_edge_c;
  logic [AW-1:0] a_ext_c;
  logic [XW-1:0] b_ext_c;
  logic [2:0]    window_c;
  logic [AW-1:0] partial_c;

  assign start_edge_c = start & ~start_q;

  // Extension happens once at launch; a is taken straight to accumulator width.
  assign a_ext_c = signed_mode ? {{(AW-WIDTH){data_a[WIDTH-1]}}, data_a}
                               : {{(AW-WIDTH){1'b0}}, data_a};
  assign b_ext_c = signed_mode ? {{2{data_b[WIDTH-1]}}, data_b}
                               : {2'b00, data_b};

  // b shifts right and a shifts left by two per digit, so the window is always the low bits.
  assign window_c = {b_q[1], b_q[0], prev_q};

  always_comb begin
    partial_c = '0;
    case (window_c)
      3'b001, 3'b010: partial_c = a_q;
      3'b011:         partial_c = a_q << 1;
      3'b100:         partial_c = AW'(0) - (a_q << 1);
      3'b101, 3'b110: partial_c = AW'(0) - a_q;
      default:        partial_c = '0;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      start_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      prev_q     <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      acc_mode_q <= 1'b0;
      irq_en_q   <= 1'b0;
      busy       <= 1'b0;
      irq        <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= start;
      a_q        <= a_d;
      b_q        <= b_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      acc_mode_q <= acc_mode_d;
      irq_en_q   <= irq_en_d;
      busy       <= busy_d;
      irq        <= irq_d;
      done       <= done_d;
      result     <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_edge_c) state_d = S_RUN;
      S_RUN:  if (cnt_q == CW'(ITER - 1)) state_d = S_DONE;
      S_DONE: state_d = irq_en_q ? S_WAIT : S_IDLE;
      S_WAIT: if (ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    prev_d     = prev_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    acc_mode_d = acc_mode_q;
    irq_en_d   = irq_en_q;
    busy_d     = busy;
    irq_d      = irq;
    done_d     = 1'b0;
    result_d   = result;
    case (state_q)
      S_IDLE: begin
        if (start_edge_c) begin
          busy_d     = 1'b1;
          a_d        = a_ext_c;
          b_d        = b_ext_c;
          prev_d     = 1'b0;
          cnt_d      = '0;
          acc_d      = '0;
          acc_mode_d = acc_mode;
          irq_en_d   = irq_enable;
        end
      end
      S_RUN: begin
        acc_d  = acc_q + partial_c;
        a_d    = a_q << 2;
        b_d    = b_q >> 2;
        prev_d = b_q[1];
        cnt_d  = cnt_q + CW'(1);
      end
      S_DONE: begin
        result_d = acc_mode_q ? result + acc_q[RW-1:0] : acc_q[RW-1:0];
        done_d   = 1'b1;
        if (irq_en_q) irq_d = 1'b1;
        else          busy_d = 1'b0;
      end
      S_WAIT: begin
        if (ack) begin
          irq_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Directed bench for booth_mult_param (WIDTH=16): products, latency, MAC wrap,
// irq/ack handshake, start-level behaviour and mid-operation reset.
module tb_booth_mult_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ack;
  logic        irq_enable;
  logic        signed_mode;
  logic        acc_mode;
  logic [15:0] data_a;
  logic [15:0] data_b;
  logic        busy;
  logic        irq;
  logic        done;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;

  booth_mult_param #(.WIDTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .irq_enable  (irq_enable),
    .signed_mode (signed_mode),
    .acc_mode    (acc_mode),
    .data_a      (data_a),
    .data_b      (data_b),
    .busy        (busy),
    .irq         (irq),
    .done        (done),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with a start edge, then scrambles every latched input.
  task automatic launch(input logic sm, input logic am, input logic ie,
                        input logic [15:0] a, input logic [15:0] b);
    signed_mode = sm;
    acc_mode    = am;
    irq_enable  = ie;
    data_a      = a;
    data_b      = b;
    start       = 1'b1;
    step();
    signed_mode = ~sm;
    acc_mode    = ~am;
    irq_enable  = ~ie;
    data_a      = ~a;
    data_b      = b ^ 16'h5a5a;
  endtask

  // Counts clocks after the sampling edge until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic op_check(input string tag, input logic sm, input logic am,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp);
    int n;
    launch(sm, am, 1'b0, a, b);
    start = 1'b0;
    chk({tag, "_busy_start"}, 64'(busy), 64'd1);
    wait_done(n);
    chk({tag, "_latency"}, 64'(n), 64'd10);
    chk({tag, "_result"}, 64'(result), 64'(exp));
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int n;
    int hold_cnt;
    int stray;
    reset       = 1'b1;
    start       = 1'b0;
    ack         = 1'b0;
    irq_enable  = 1'b0;
    signed_mode = 1'b0;
    acc_mode    = 1'b0;
    data_a      = '0;
    data_b      = '0;
    step();
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_irq", 64'(irq), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    reset = 1'b0;
    step();

    op_check("s_m3x7", 1'b1, 1'b0, 16'hFFFD, 16'h0007, 32'hFFFFFFEB);
    op_check("u_ffff_sq", 1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    op_check("s_ffff_sq", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 32'h00000001);
    op_check("s_8000_sq", 1'b1, 1'b0, 16'h8000, 16'h8000, 32'h40000000);
    op_check("s_8000x7fff", 1'b1, 1'b0, 16'h8000, 16'h7FFF, 32'hC0008000);
    op_check("mac_base", 1'b1, 1'b0, 16'hFFFD, 16'h0007, 32'hFFFFFFEB);
    op_check("mac_wrap", 1'b1, 1'b1, 16'h0005, 16'h0005, 32'h00000004);

    // irq mode, start held high throughout, stray ack during RUN
    launch(1'b1, 1'b0, 1'b1, 16'h0005, 16'h0005);
    n = 0;
    while (done !== 1'b1 && n < 50) begin
      ack = (n == 3);
      step();
      n++;
    end
    ack = 1'b0;
    chk("irq_latency", 64'(n), 64'd10);
    chk("irq_result", 64'(result), 64'h19);
    chk("irq_set", 64'({irq, busy}), 64'b11);
    hold_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      start = (c != 10);
      step();
      if (irq === 1'b1 && busy === 1'b1 && done === 1'b0) hold_cnt++;
    end
    chk("irq_hold20", 64'(hold_cnt), 64'd20);
    chk("wait_result_stable", 64'(result), 64'h19);
    ack = 1'b1;
    step();
    ack = 1'b0;
    chk("ack_clear", 64'({irq, busy}), 64'b00);
    stray = 0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0 || irq !== 1'b0) stray++;
    end
    chk("no_retrigger", 64'(stray), 64'd0);
    chk("no_retrigger_result", 64'(result), 64'h19);
    start = 1'b0;
    step();

    // reset in the middle of RUN, then a fresh accumulate from a cleared result
    launch(1'b0, 1'b0, 1'b0, 16'h1234, 16'h5678);
    start = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    chk("midrst_outputs", 64'({busy, irq, done}), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    reset = 1'b0;
    step();
    op_check("post_rst_mac", 1'b0, 1'b1, 16'h1234, 16'h5678, 32'h06260060);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
